// File: rtl/ball_sprite_gen_if.sv
// ball_sprite_gen_if: scan pixel stream in, sprite hit flag out.
interface ball_sprite_gen_if #(parameter int COORD_W = 10);
  logic pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic ball_on;
  logic out_valid;
  modport master(output pix_valid, pix_x, pix_y, input ball_on, out_valid);
  modport slave(input pix_valid, pix_x, pix_y, output ball_on, out_valid);
endinterface

// File: rtl/ball_sprite_gen.sv
// ball_sprite_gen: arithmetic ball sprite renderer, 2-cycle latency, per-frame lit-pixel count.
module ball_sprite_gen #(
  parameter int SIZE = 6,
  parameter int COORD_W = 10,
  parameter int CNT_W = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] ball_x_in,
  input  logic [COORD_W-1:0] ball_y_in,
  input  logic [1:0]         shape_sel_in,
  ball_sprite_gen_if.slave   px,
  output logic [CNT_W-1:0]   on_count
);
  localparam int CW = $clog2(SIZE);
  localparam int PW = 2 * (CW + 2);
  localparam logic [COORD_W:0] SZ_C = (COORD_W + 1)'(SIZE);
  localparam logic [CW:0] S1 = (CW + 1)'(SIZE - 1);
  localparam logic [PW-1:0] SZ_P = PW'(SIZE);
  localparam logic [PW-1:0] R_OUT = PW'(SIZE * SIZE);
  localparam logic [PW-1:0] R_IN = PW'((SIZE - 2) * (SIZE - 2));
  logic [COORD_W-1:0] sx, sy;
  logic [1:0] sh, sh1;
  logic [COORD_W:0] col, row;
  logic box, v1, b1, hit;
  logic [CW-1:0] c1, r1;
  logic [CW:0] tx, ty, ax, ay;
  logic [PW-1:0] ex, ey, d2, md;
  logic [CNT_W-1:0] acc, acc_n;
  // extra top bit keeps a ball near the right/bottom edge from wrapping onto x/y = 0
  assign col = {1'b0, px.pix_x} - {1'b0, sx};
  assign row = {1'b0, px.pix_y} - {1'b0, sy};
  assign box = !col[COORD_W] && !row[COORD_W] && col < SZ_C && row < SZ_C;
  // doubled centred coordinates keep the sprite centre on an integer grid
  assign tx = {c1, 1'b0};
  assign ty = {r1, 1'b0};
  assign ax = tx >= S1 ? tx - S1 : S1 - tx;
  assign ay = ty >= S1 ? ty - S1 : S1 - ty;
  assign ex = PW'(ax);
  assign ey = PW'(ay);
  assign d2 = ex * ex + ey * ey;
  assign md = ex + ey;
  assign hit = sh1 == 2'd0 ? 1'b1 :
               sh1 == 2'd2 ? md <= SZ_P :
               d2 <= R_OUT && (sh1 == 2'd1 || d2 >= R_IN);
  assign acc_n = (&acc) ? acc : acc + CNT_W'(px.out_valid & px.ball_on);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sx <= '0;
      sy <= '0;
      sh <= 2'd1;
      v1 <= 1'b0;
      b1 <= 1'b0;
      c1 <= '0;
      r1 <= '0;
      sh1 <= '0;
      px.ball_on <= 1'b0;
      px.out_valid <= 1'b0;
      acc <= '0;
      on_count <= '0;
    end else begin
      if (frame_start) begin
        sx <= ball_x_in;
        sy <= ball_y_in;
        sh <= shape_sel_in;
        on_count <= acc_n;
        acc <= '0;
      end else acc <= acc_n;
      v1 <= px.pix_valid;
      b1 <= box;
      c1 <= col[CW-1:0];
      r1 <= row[CW-1:0];
      sh1 <= sh;
      px.ball_on <= v1 & b1 & hit;
      px.out_valid <= v1;
    end
endmodule
